ultrasonido_scheduler: RTL and testbench

//  Round-robin scheduler that shares one ultrasonic ranging block among N_REQ requesters.
//  It sits between the requesters (CPU register bank, navigation FSM, ...) and the ranging block's

---
 rtl/ultrasonido_scheduler.sv | 235 +++++++++++++++++++++++
 tb/tb_ultrasonido_scheduler.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ultrasonido_scheduler.sv
// ---------------------------------------------------------------------------
// ultrasonido_scheduler
//   Round-robin arbiter that shares a single ultrasonic ranging block among
//   N_REQ requesters. Only one measurement runs at a time. After each ping
//   the block enforces a quiet gap. A watchdog aborts a measurement whose
//   echo never arrives, and the ranging block then gets a one-cycle reset
//   pulse. Every result is returned tagged with the id of the requester
//   that was served.
// ---------------------------------------------------------------------------
module ultrasonido_scheduler #(
    parameter int N_REQ          = 2,
    parameter int GAP_CYCLES     = 6000000,
    parameter int TIMEOUT_CYCLES = 4000000,
    parameter int ID_W           = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [N_REQ-1:0] req,
    output logic             busy,
    output logic             rsp_valid,
    output logic [ID_W-1:0]  rsp_id,
    output logic [7:0]       rsp_dist,
    output logic             rsp_timeout,
    output logic             orden,
    output logic             sensor_rst,
    input  logic             done,
    input  logic [7:0]       d
);

    // The gap and the watchdog never run at the same time, so they share
    // one counter. The counter is sized for the longer of the two intervals.
    localparam int MAX_CYC = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
    localparam logic [ID_W-1:0]  LAST_IDX     = ID_W'(N_REQ - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_DONE,
        S_REPORT,
        S_GAP
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [CNT_W-1:0]   cnt;
    logic [ID_W-1:0]    cur_id;
    logic [ID_W-1:0]    last_id;
    logic [N_REQ-1:0]   pending;
    logic [N_REQ-1:0]   clr_mask;
    logic               done_q;
    logic               done_edge;

    logic               grant_found;
    logic [ID_W-1:0]    grant_id;
    logic [ID_W-1:0]    scan_idx;

    // Control strobes from the FSM to the datapath registers.
    logic               load_grant;
    logic               cnt_clr;
    logic               cnt_inc;
    logic               cap_result;
    logic               cap_timeout;
    logic               clr_pend;

    // Only the rising edge of done marks a completed measurement.
    assign done_edge = done & ~done_q;

    // Round-robin search: the first pending id from last_id+1, wrapping modulo N_REQ.
    always_comb begin
        // NOTE: every variable written here gets a default value first.
        // Otherwise a path that skips an assignment infers a latch.
        grant_found = 1'b0;
        grant_id    = '0;
        scan_idx    = last_id;
        for (int k = 0; k < N_REQ; k++) begin
            if (scan_idx == LAST_IDX) begin
                scan_idx = '0;
            end else begin
                scan_idx = scan_idx + 1'b1;
            end
            if (!grant_found && pending[scan_idx]) begin
                grant_found = 1'b1;
                grant_id    = scan_idx;
            end
        end
    end

    // Mask that drops the pending bit of the requester being reported.
    always_comb begin
        clr_mask = '0;
        if (clr_pend) begin
            clr_mask[cur_id] = 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so that every
        // register samples pre-edge values, whatever the statement order.
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic and per-state outputs/strobes.
    always_comb begin
        state_next  = state;
        busy        = 1'b0;
        orden       = 1'b0;
        rsp_valid   = 1'b0;
        load_grant  = 1'b0;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        cap_result  = 1'b0;
        cap_timeout = 1'b0;
        clr_pend    = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (enable && grant_found) begin
                    load_grant = 1'b1;
                    state_next = S_ISSUE;
                end
            end

            S_ISSUE: begin
                busy       = 1'b1;
                orden      = 1'b1;
                cnt_clr    = 1'b1;
                state_next = S_WAIT_DONE;
            end

            S_WAIT_DONE: begin
                busy = 1'b1;
                // An echo in the expiry cycle still counts as a valid result.
                if (done_edge) begin
                    cap_result = 1'b1;
                    state_next = S_REPORT;
                end else if (cnt == TIMEOUT_LAST) begin
                    cap_timeout = 1'b1;
                    state_next  = S_REPORT;
                end else begin
                    cnt_inc = 1'b1;
                end
            end

            S_REPORT: begin
                busy       = 1'b1;
                rsp_valid  = 1'b1;
                clr_pend   = 1'b1;
                cnt_clr    = 1'b1;
                state_next = S_GAP;
            end

            S_GAP: begin
                if (cnt == GAP_LAST) begin
                    state_next = S_IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Request capture: set has priority over the clear from REPORT, so a
    // requester that is still asserting stays queued. done is delayed one
    // cycle for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            done_q  <= 1'b0;
        end else begin
            pending <= (pending & ~clr_mask) | req;
            done_q  <= done;
        end
    end

    // Granted id and round-robin pointer, both updated when a grant is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_id  <= '0;
            last_id <= LAST_IDX;
        end else if (load_grant) begin
            cur_id  <= grant_id;
            last_id <= grant_id;
        end
    end

    // Shared gap/watchdog counter. The FSM exits on an equality compare, so
    // the counter never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else if (cnt_inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Result registers hold their value between rsp_valid pulses.
    // sensor_rst fires in the cycle after a timed-out report.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_id      <= '0;
            rsp_dist    <= '0;
            rsp_timeout <= 1'b0;
            sensor_rst  <= 1'b0;
        end else begin
            sensor_rst <= rsp_valid & rsp_timeout;
            if (cap_result) begin
                rsp_id      <= cur_id;
                rsp_dist    <= d;
                rsp_timeout <= 1'b0;
            end else if (cap_timeout) begin
                rsp_id      <= cur_id;
                rsp_dist    <= 8'hFF;
                rsp_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ultrasonido_scheduler.sv
// ---------------------------------------------------------------------------
// tb_ultrasonido_scheduler
//   Directed bench for ultrasonido_scheduler with N_REQ=3, GAP_CYCLES=20 and
//   TIMEOUT_CYCLES=50. Inputs change just after a falling edge. Outputs are
//   sampled on the falling edge, away from the active rising edge.
// ---------------------------------------------------------------------------
module tb_ultrasonido_scheduler;

    localparam int N_REQ  = 3;
    localparam int GAP    = 20;
    localparam int TMO    = 50;
    localparam int ID_W   = 2;

    logic             clk;
    logic             rst;
    logic             enable;
    logic [N_REQ-1:0] req;
    logic             busy;
    logic             rsp_valid;
    logic [ID_W-1:0]  rsp_id;
    logic [7:0]       rsp_dist;
    logic             rsp_timeout;
    logic             orden;
    logic             sensor_rst;
    logic             done;
    logic [7:0]       d;

    int n_checks = 0;
    int n_fail   = 0;

    ultrasonido_scheduler #(
        .N_REQ          (N_REQ),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TMO),
        .ID_W           (ID_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .req         (req),
        .busy        (busy),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_dist    (rsp_dist),
        .rsp_timeout (rsp_timeout),
        .orden       (orden),
        .sensor_rst  (sensor_rst),
        .done        (done),
        .d           (d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("%s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance until orden is seen or the cycle budget runs out.
    task automatic wait_orden(input int max_cyc, output int n);
        n = 0;
        while (orden !== 1'b1 && n < max_cyc) begin
            tick();
            n++;
        end
    endtask

    // Advance until rsp_valid is seen or the cycle budget runs out.
    task automatic wait_rsp(input int max_cyc, output int n);
        n = 0;
        while (rsp_valid !== 1'b1 && n < max_cyc) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        int cnt_o;
        int cnt_v;
        logic [ID_W-1:0] exp_ids [4];
        exp_ids[0] = 2'd1;
        exp_ids[1] = 2'd0;
        exp_ids[2] = 2'd1;
        exp_ids[3] = 2'd0;

        rst    = 1'b1;
        enable = 1'b1;
        req    = '0;
        done   = 1'b0;
        d      = '0;
        tick();
        tick();

        // ---------------- reset state ----------------
        check("rst_busy",        busy,        0);
        check("rst_rsp_valid",   rsp_valid,   0);
        check("rst_orden",       orden,       0);
        check("rst_sensor_rst",  sensor_rst,  0);
        check("rst_rsp_id",      rsp_id,      0);
        check("rst_rsp_dist",    rsp_dist,    0);
        check("rst_rsp_timeout", rsp_timeout, 0);

        // ---------------- 1: single request, echo 10 cycles after orden ----
        rst = 1'b0;
        tick();
        req = 3'b001;
        tick();
        req = '0;
        check("t1_no_orden_yet", orden, 0);
        tick();
        check("t1_orden", orden, 1);
        check("t1_busy", busy, 1);
        tick();
        check("t1_orden_single", orden, 0);
        repeat (9) tick();
        done = 1'b1;
        d    = 8'd42;
        tick();
        check("t1_rsp_valid", rsp_valid, 1);
        check("t1_rsp_id", rsp_id, 0);
        check("t1_rsp_dist", rsp_dist, 42);
        check("t1_rsp_timeout", rsp_timeout, 0);
        done = 1'b0;
        tick();
        check("t1_rsp_pulse", rsp_valid, 0);
        check("t1_dist_hold", rsp_dist, 42);
        check("t1_no_sensor_rst", sensor_rst, 0);

        // ---------------- 2: three requests at reset release ----------------
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 3'b111;
        tick();
        req = '0;
        tick();
        check("t2_first_orden", orden, 1);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin
                wait_orden(40, n);
                check("t2_orden_spacing", n, 22);
            end
            tick();
            done = 1'b1;
            d    = 8'(10 + k);
            tick();
            check("t2_rsp_valid", rsp_valid, 1);
            check("t2_rsp_id", rsp_id, k);
            check("t2_rsp_dist", rsp_dist, 10 + k);
            done = 1'b0;
        end

        // ---------------- 3: missing echo -> timeout ----------------
        req = 3'b001;
        tick();
        req = '0;
        wait_orden(40, n);
        check("t3_orden_after_gap", n, 21);
        wait_rsp(60, n);
        check("t3_timeout_latency", n, 51);
        check("t3_rsp_valid", rsp_valid, 1);
        check("t3_rsp_id", rsp_id, 0);
        check("t3_rsp_dist", rsp_dist, 8'hFF);
        check("t3_rsp_timeout", rsp_timeout, 1);
        check("t3_sensor_rst_not_yet", sensor_rst, 0);
        tick();
        check("t3_sensor_rst", sensor_rst, 1);
        check("t3_rsp_pulse", rsp_valid, 0);
        tick();
        check("t3_sensor_rst_pulse", sensor_rst, 0);
        req = 3'b010;
        tick();
        req = '0;
        wait_orden(40, n);
        check("t3_next_orden", n, 19);
        tick();
        done = 1'b1;
        d    = 8'd99;
        tick();
        check("t3_next_valid", rsp_valid, 1);
        check("t3_next_id", rsp_id, 1);
        check("t3_next_dist", rsp_dist, 99);
        check("t3_next_timeout", rsp_timeout, 0);
        done = 1'b0;

        // ---------------- 4: echo exactly in the timeout cycle ----------------
        req = 3'b100;
        tick();
        req = '0;
        wait_orden(40, n);
        check("t4_orden", n, 21);
        repeat (50) tick();
        done = 1'b1;
        d    = 8'd7;
        tick();
        check("t4_rsp_valid", rsp_valid, 1);
        check("t4_rsp_id", rsp_id, 2);
        check("t4_rsp_dist", rsp_dist, 7);
        check("t4_rsp_timeout", rsp_timeout, 0);
        done = 1'b0;
        tick();
        check("t4_no_sensor_rst", sensor_rst, 0);

        // ---------------- 5: enable gating, then reset mid-measurement ----
        enable = 1'b0;
        req    = 3'b010;
        tick();
        req   = '0;
        cnt_o = 0;
        repeat (40) begin
            tick();
            if (orden === 1'b1) cnt_o++;
        end
        check("t5_no_orden_disabled", cnt_o, 0);
        check("t5_idle_not_busy", busy, 0);
        enable = 1'b1;
        tick();
        check("t5_enable_orden", orden, 1);
        tick();
        tick();
        check("t5_busy_wait", busy, 1);
        rst = 1'b1;
        tick();
        check("t5_rst_busy", busy, 0);
        check("t5_rst_orden", orden, 0);
        check("t5_rst_rsp_valid", rsp_valid, 0);
        check("t5_rst_rsp_id", rsp_id, 0);
        check("t5_rst_rsp_dist", rsp_dist, 0);
        check("t5_rst_timeout", rsp_timeout, 0);
        check("t5_rst_sensor_rst", sensor_rst, 0);
        rst  = 1'b0;
        done = 1'b1;
        d    = 8'd55;
        tick();
        done  = 1'b0;
        cnt_o = 0;
        cnt_v = 0;
        repeat (30) begin
            tick();
            if (orden === 1'b1) cnt_o++;
            if (rsp_valid === 1'b1) cnt_v++;
        end
        check("t5_pending_dropped", cnt_o, 0);
        check("t5_no_rsp_after_rst", cnt_v, 0);

        // ---------------- 6: held req[1] vs pulsed req[0] ----------------
        req = 3'b010;
        for (int k = 0; k < 4; k++) begin
            wait_orden(60, n);
            check("t6_orden_seen", orden, 1);
            tick();
            done = 1'b1;
            d    = 8'(k);
            tick();
            check("t6_rsp_valid", rsp_valid, 1);
            check("t6_rsp_id", rsp_id, exp_ids[k]);
            done = 1'b0;
            req  = 3'b011;
            tick();
            req = 3'b010;
        end
        req = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
